uart_tx_scheduler: RTL and testbench

- Shares the interface and ext1 UART transmitters between two packet requesters: the menu FSM and the external-response path.
- Each packet is two bytes (byte1, then byte2), sent to any subset of the two UARTs.
- Replaces ad-hoc TX sequencing with round-robin arbitration, packet latching, done-tracking per channel, and a watchdog timeout.
- Sits between the requesters and the two uart_top TX inputs in the top level.

---
 rtl/uart_tx_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares the interface UART and the ext1 UART transmitters between two packet
// requesters: the menu FSM and the external-response path. Each packet is two
// bytes (byte1, then byte2), sent to any subset of the two UARTs. Requests are
// arbitrated round-robin, the winning packet is latched, completion is tracked
// per channel, and a watchdog aborts a byte whose tx_done never arrives.
//
// Ports
//   clk_50mhz, reset_n_internal    clock, asynchronous active-low reset
//   req_menu / menu_byte1/2 / menu_dest   menu packet request (level, held to ack)
//   req_ext  / ext_byte1/2  / ext_dest    external packet request
//     dest bit0 = interface UART, bit1 = ext1 UART
//   tx_active_if/ext1, tx_done_if/ext1    UART status (done is a 1-cycle pulse)
//   tx_dv_if/ext1, tx_byte_if/ext1        1-cycle TX strobes and data
//   ack_menu, ack_ext              1-cycle packet-complete pulse
//   err_timeout                    1-cycle pulse with the ack of an aborted packet
//   busy                           high in every state except IDLE
//   grant_src                      0 = menu, 1 = ext; current or last packet source
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int TX_TIMEOUT_CYCLES = 250_000,
  parameter int CNT_W             = 20
) (
  input  logic       clk_50mhz,
  input  logic       reset_n_internal,
  input  logic       req_menu,
  input  logic [7:0] menu_byte1,
  input  logic [7:0] menu_byte2,
  input  logic [1:0] menu_dest,
  input  logic       req_ext,
  input  logic [7:0] ext_byte1,
  input  logic [7:0] ext_byte2,
  input  logic [1:0] ext_dest,
  input  logic       tx_active_if,
  input  logic       tx_done_if,
  input  logic       tx_active_ext1,
  input  logic       tx_done_ext1,
  output logic       tx_dv_if,
  output logic       tx_dv_ext1,
  output logic [7:0] tx_byte_if,
  output logic [7:0] tx_byte_ext1,
  output logic       ack_menu,
  output logic       ack_ext,
  output logic       err_timeout,
  output logic       busy,
  output logic       grant_src
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND1 = 3'd1;
  localparam logic [2:0] S_WAIT1 = 3'd2;
  localparam logic [2:0] S_SEND2 = 3'd3;
  localparam logic [2:0] S_WAIT2 = 3'd4;
  localparam logic [2:0] S_ACK   = 3'd5;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TX_TIMEOUT_CYCLES);

  logic [2:0]       r_state;
  logic [7:0]       r_byte1;
  logic [7:0]       r_byte2;
  logic [1:0]       r_dest;
  logic [1:0]       r_done;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_grant;
  logic             r_grant_src;
  logic             r_tx_dv_if;
  logic             r_tx_dv_ext1;
  logic [7:0]       r_tx_byte_if;
  logic [7:0]       r_tx_byte_ext1;
  logic             r_ack_menu;
  logic             r_ack_ext;
  logic             r_err;
  logic             r_busy;

  logic [1:0] w_active;
  logic [1:0] w_done_in;
  logic [1:0] w_done_acc;
  logic       w_all_done;
  logic       w_chan_idle;
  logic       w_timeout;
  logic       w_req_any;
  logic       w_pick_ext;
  logic [7:0] w_send_byte;

  // Channel vectors use the dest encoding: bit0 = interface, bit1 = ext1.
  assign w_active    = {tx_active_ext1, tx_active_if};
  assign w_done_in   = {tx_done_ext1, tx_done_if};
  // Done pulses on unselected channels are masked off here.
  assign w_done_acc  = r_done | (w_done_in & r_dest);
  assign w_all_done  = (w_done_acc & r_dest) == r_dest;
  assign w_chan_idle = (w_active & r_dest) == 2'b00;
  assign w_timeout   = (r_cnt == TIMEOUT_VAL);
  assign w_req_any   = req_menu | req_ext;
  // On a tie the source that did not win last time is served.
  assign w_pick_ext  = req_ext & (~req_menu | ~r_last_grant);
  assign w_send_byte = (r_state == S_SEND1) ? r_byte1 : r_byte2;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_50mhz or negedge reset_n_internal) begin
    if (!reset_n_internal) begin
      r_state        <= S_IDLE;
      r_byte1        <= '0;
      r_byte2        <= '0;
      r_dest         <= '0;
      r_done         <= '0;
      r_cnt          <= '0;
      r_last_grant   <= 1'b1;
      r_grant_src    <= 1'b0;
      r_tx_dv_if     <= 1'b0;
      r_tx_dv_ext1   <= 1'b0;
      r_tx_byte_if   <= '0;
      r_tx_byte_ext1 <= '0;
      r_ack_menu     <= 1'b0;
      r_ack_ext      <= 1'b0;
      r_err          <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle pulses unless re-asserted below.
      r_tx_dv_if   <= 1'b0;
      r_tx_dv_ext1 <= 1'b0;
      r_ack_menu   <= 1'b0;
      r_ack_ext    <= 1'b0;
      r_err        <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_byte1      <= w_pick_ext ? ext_byte1 : menu_byte1;
            r_byte2      <= w_pick_ext ? ext_byte2 : menu_byte2;
            r_dest       <= w_pick_ext ? ext_dest  : menu_dest;
            r_grant_src  <= w_pick_ext;
            r_last_grant <= w_pick_ext;
            r_busy       <= 1'b1;
            r_state      <= S_SEND1;
          end
        end

        S_SEND1, S_SEND2: begin
          if (r_dest == 2'b00) begin
            // Nothing to send: complete the packet without any strobe.
            r_ack_menu <= ~r_grant_src;
            r_ack_ext  <= r_grant_src;
            r_state    <= S_ACK;
          end else if (w_chan_idle) begin
            if (r_dest[0]) begin
              r_tx_dv_if   <= 1'b1;
              r_tx_byte_if <= w_send_byte;
            end
            if (r_dest[1]) begin
              r_tx_dv_ext1   <= 1'b1;
              r_tx_byte_ext1 <= w_send_byte;
            end
            // Clearing here discards any done pulse from an earlier transfer
            // that lands in this cycle; flags only accumulate in WAIT states.
            r_done  <= 2'b00;
            r_cnt   <= '0;
            r_state <= (r_state == S_SEND1) ? S_WAIT1 : S_WAIT2;
          end
        end

        S_WAIT1, S_WAIT2: begin
          r_done <= w_done_acc;
          if (w_all_done) begin
            if (r_state == S_WAIT1) begin
              r_state <= S_SEND2;
            end else begin
              r_ack_menu <= ~r_grant_src;
              r_ack_ext  <= r_grant_src;
              r_state    <= S_ACK;
            end
          end else if (w_timeout) begin
            // Abort: remaining bytes are skipped and the ack carries the error.
            r_err      <= 1'b1;
            r_ack_menu <= ~r_grant_src;
            r_ack_ext  <= r_grant_src;
            r_state    <= S_ACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_ACK: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_dv_if     = r_tx_dv_if;
  assign tx_dv_ext1   = r_tx_dv_ext1;
  assign tx_byte_if   = r_tx_byte_if;
  assign tx_byte_ext1 = r_tx_byte_ext1;
  assign ack_menu     = r_ack_menu;
  assign ack_ext      = r_ack_ext;
  assign err_timeout  = r_err;
  assign busy         = r_busy;
  assign grant_src    = r_grant_src;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Self-checking bench for uart_tx_scheduler. Two requester processes drive the
// menu and ext request ports from packet queues; two UART models answer each
// strobe with active/done after a fixed delay (a strobe carrying the byte MUTE
// is never answered). A monitor records every strobe/ack as an event; test
// tasks push expected events and compare them in order against the monitor.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam int         TIMEOUT    = 50;
  localparam logic [7:0] MUTE       = 8'hDD;
  localparam int         K_IF       = 0;
  localparam int         K_EXT1     = 1;
  localparam int         K_ACK_MENU = 2;
  localparam int         K_ACK_EXT  = 3;
  localparam int         K_ERR_ONLY = 4;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       gsrc;
    int         cyc;
  } ev_t;

  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [1:0] dest;
  } pkt_t;

  logic       clk_50mhz = 1'b0;
  logic       reset_n_internal;
  logic       req_menu, req_ext;
  logic [7:0] menu_byte1, menu_byte2, ext_byte1, ext_byte2;
  logic [1:0] menu_dest, ext_dest;
  logic       tx_active_if, tx_done_if, tx_active_ext1, tx_done_ext1;
  logic       tx_dv_if, tx_dv_ext1;
  logic [7:0] tx_byte_if, tx_byte_ext1;
  logic       ack_menu, ack_ext, err_timeout, busy, grant_src;

  logic m_active_if, m_done_if, m_active_ext1, m_done_ext1;
  logic force_active_if, inj_done_ext1;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   menu_req_cyc, ext_req_cyc;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  pkt_t menu_txq[$];
  pkt_t ext_txq[$];

  assign tx_active_if   = m_active_if | force_active_if;
  assign tx_done_if     = m_done_if;
  assign tx_active_ext1 = m_active_ext1;
  assign tx_done_ext1   = m_done_ext1 | inj_done_ext1;

  uart_tx_scheduler #(
    .TX_TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W            (20)
  ) dut (
    .clk_50mhz       (clk_50mhz),
    .reset_n_internal(reset_n_internal),
    .req_menu        (req_menu),
    .menu_byte1      (menu_byte1),
    .menu_byte2      (menu_byte2),
    .menu_dest       (menu_dest),
    .req_ext         (req_ext),
    .ext_byte1       (ext_byte1),
    .ext_byte2       (ext_byte2),
    .ext_dest        (ext_dest),
    .tx_active_if    (tx_active_if),
    .tx_done_if      (tx_done_if),
    .tx_active_ext1  (tx_active_ext1),
    .tx_done_ext1    (tx_done_ext1),
    .tx_dv_if        (tx_dv_if),
    .tx_dv_ext1      (tx_dv_ext1),
    .tx_byte_if      (tx_byte_if),
    .tx_byte_ext1    (tx_byte_ext1),
    .ack_menu        (ack_menu),
    .ack_ext         (ack_ext),
    .err_timeout     (err_timeout),
    .busy            (busy),
    .grant_src       (grant_src)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  initial forever begin
    @(posedge clk_50mhz);
    cyc++;
  end

  // Monitor: one event per strobe / ack, stamped with the cycle number.
  initial forever begin
    @(negedge clk_50mhz);
    if (tx_dv_if)   obs_q.push_back('{K_IF, tx_byte_if, grant_src, cyc});
    if (tx_dv_ext1) obs_q.push_back('{K_EXT1, tx_byte_ext1, grant_src, cyc});
    if (ack_menu)   obs_q.push_back('{K_ACK_MENU, {7'd0, err_timeout}, grant_src, cyc});
    if (ack_ext)    obs_q.push_back('{K_ACK_EXT, {7'd0, err_timeout}, grant_src, cyc});
    if (err_timeout && !ack_menu && !ack_ext)
      obs_q.push_back('{K_ERR_ONLY, 8'h01, grant_src, cyc});
  end

  // UART models: active during the transfer, done pulse 3 cycles after strobe.
  initial begin
    m_active_if = 1'b0;
    m_done_if   = 1'b0;
    forever begin
      @(negedge clk_50mhz);
      if (tx_dv_if && tx_byte_if != MUTE) begin
        m_active_if = 1'b1;
        repeat (3) @(negedge clk_50mhz);
        m_done_if = 1'b1;
        @(negedge clk_50mhz);
        m_done_if   = 1'b0;
        m_active_if = 1'b0;
      end
    end
  end

  initial begin
    m_active_ext1 = 1'b0;
    m_done_ext1   = 1'b0;
    forever begin
      @(negedge clk_50mhz);
      if (tx_dv_ext1 && tx_byte_ext1 != MUTE) begin
        m_active_ext1 = 1'b1;
        repeat (3) @(negedge clk_50mhz);
        m_done_ext1 = 1'b1;
        @(negedge clk_50mhz);
        m_done_ext1   = 1'b0;
        m_active_ext1 = 1'b0;
      end
    end
  end

  // Requesters: hold req until ack, drop it in the following cycle.
  initial begin : menu_requester
    pkt_t p;
    req_menu = 1'b0; menu_byte1 = '0; menu_byte2 = '0; menu_dest = '0; menu_req_cyc = 0;
    forever begin
      @(posedge clk_50mhz); #1;
      if (menu_txq.size() != 0) begin
        p = menu_txq.pop_front();
        menu_byte1 = p.b1; menu_byte2 = p.b2; menu_dest = p.dest;
        req_menu = 1'b1;
        menu_req_cyc = cyc;
        for (int n = 0; n < 5000; n++) begin
          @(negedge clk_50mhz);
          if (ack_menu) break;
        end
        @(posedge clk_50mhz); #1;
        req_menu = 1'b0; menu_byte1 = ~p.b1; menu_byte2 = ~p.b2; menu_dest = ~p.dest;
      end
    end
  end

  initial begin : ext_requester
    pkt_t p;
    req_ext = 1'b0; ext_byte1 = '0; ext_byte2 = '0; ext_dest = '0; ext_req_cyc = 0;
    forever begin
      @(posedge clk_50mhz); #1;
      if (ext_txq.size() != 0) begin
        p = ext_txq.pop_front();
        ext_byte1 = p.b1; ext_byte2 = p.b2; ext_dest = p.dest;
        req_ext = 1'b1;
        ext_req_cyc = cyc;
        for (int n = 0; n < 5000; n++) begin
          @(negedge clk_50mhz);
          if (ack_ext) break;
        end
        @(posedge clk_50mhz); #1;
        req_ext = 1'b0; ext_byte1 = ~p.b1; ext_byte2 = ~p.b2; ext_dest = ~p.dest;
      end
    end
  end

  function automatic ev_t mk(int k, logic [7:0] d, logic g);
    ev_t e;
    e.kind = k; e.data = d; e.gsrc = g; e.cyc = 0;
    return e;
  endfunction

  function automatic pkt_t pk(logic [7:0] b1, logic [7:0] b2, logic [1:0] dest);
    pkt_t p;
    p.b1 = b1; p.b2 = b2; p.dest = dest;
    return p;
  endfunction

  // Bounded wait for the next monitored event.
  task automatic get_obs(output ev_t o, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 300) begin
      @(negedge clk_50mhz);
      n++;
    end
    ok = (obs_q.size() != 0);
    if (ok) o = obs_q.pop_front();
    else    o = '{-1, 8'h00, 1'b0, -1};
  endtask

  task automatic test_reset();
    reset_n_internal = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    n_tests++;
    if ({tx_dv_if, tx_dv_ext1, tx_byte_if, tx_byte_ext1, ack_menu, ack_ext,
         err_timeout, busy, grant_src} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 000000", {tx_dv_if, tx_dv_ext1,
               tx_byte_if, tx_byte_ext1, ack_menu, ack_ext, err_timeout, busy, grant_src});
    end
    reset_n_internal = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    n_tests++;
    if ({tx_dv_if, tx_dv_ext1, ack_menu, ack_ext, err_timeout, busy} !== 6'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got dv/ack/err/busy=%b, want 000000",
               {tx_dv_if, tx_dv_ext1, ack_menu, ack_ext, err_timeout, busy});
    end
  endtask

  task automatic test_tie();
    ev_t o, e;
    bit  ok;
    for (int r = 0; r < 2; r++) begin
      repeat (4) @(negedge clk_50mhz);
      exp_q.push_back(mk(K_IF, 8'hA1, 1'b0));
      exp_q.push_back(mk(K_IF, 8'hA2, 1'b0));
      exp_q.push_back(mk(K_ACK_MENU, 8'h00, 1'b0));
      exp_q.push_back(mk(K_EXT1, 8'hB1, 1'b1));
      exp_q.push_back(mk(K_EXT1, 8'hB2, 1'b1));
      exp_q.push_back(mk(K_ACK_EXT, 8'h00, 1'b1));
      menu_txq.push_back(pk(8'hA1, 8'hA2, 2'b01));
      ext_txq.push_back(pk(8'hB1, 8'hB2, 2'b10));
      for (int i = 0; exp_q.size() != 0; i++) begin
        e = exp_q.pop_front(); get_obs(o, ok); n_tests++;
        if (!ok || o.kind !== e.kind || o.data !== e.data || o.gsrc !== e.gsrc) begin
          n_fail++;
          $display("FAIL tie round%0d ev%0d: got ok=%0d kind=%0d data=%h src=%b, want kind=%0d data=%h src=%b",
                   r, i, ok, o.kind, o.data, o.gsrc, e.kind, e.data, e.gsrc);
        end
      end
    end
  endtask

  task automatic test_menu_only();
    ev_t o, e;
    bit  ok;
    int  t[5];
    repeat (4) @(negedge clk_50mhz);
    exp_q.push_back(mk(K_IF, 8'h41, 1'b0));
    exp_q.push_back(mk(K_EXT1, 8'h41, 1'b0));
    exp_q.push_back(mk(K_IF, 8'h17, 1'b0));
    exp_q.push_back(mk(K_EXT1, 8'h17, 1'b0));
    exp_q.push_back(mk(K_ACK_MENU, 8'h00, 1'b0));
    menu_txq.push_back(pk(8'h41, 8'h17, 2'b11));
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front(); get_obs(o, ok); n_tests++; t[i] = o.cyc;
      if (!ok || o.kind !== e.kind || o.data !== e.data || o.gsrc !== e.gsrc) begin
        n_fail++;
        $display("FAIL menu_only ev%0d: got ok=%0d kind=%0d data=%h src=%b, want kind=%0d data=%h src=%b",
                 i, ok, o.kind, o.data, o.gsrc, e.kind, e.data, e.gsrc);
      end
    end
    n_tests++;
    if (t[0] != menu_req_cyc + 2) begin
      n_fail++;
      $display("FAIL menu_latency: strobe in cycle %0d, want %0d", t[0], menu_req_cyc + 2);
    end
    n_tests++;
    if (t[1] != t[0] || t[3] != t[2]) begin
      n_fail++;
      $display("FAIL dual_strobe_align: cycles %0d/%0d and %0d/%0d, want equal pairs",
               t[0], t[1], t[2], t[3]);
    end
  endtask

  task automatic test_ext_if_only();
    ev_t o, e;
    bit  ok;
    repeat (4) @(negedge clk_50mhz);
    exp_q.push_back(mk(K_IF, 8'h52, 1'b1));
    exp_q.push_back(mk(K_IF, 8'h99, 1'b1));
    exp_q.push_back(mk(K_ACK_EXT, 8'h00, 1'b1));
    ext_txq.push_back(pk(8'h52, 8'h99, 2'b01));
    // Stray ext1 done pulses while only the interface UART is selected.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_50mhz); inj_done_ext1 = 1'b1;
      @(negedge clk_50mhz); inj_done_ext1 = 1'b0;
    end
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front(); get_obs(o, ok); n_tests++;
      if (!ok || o.kind !== e.kind || o.data !== e.data || o.gsrc !== e.gsrc) begin
        n_fail++;
        $display("FAIL ext_if_only ev%0d: got ok=%0d kind=%0d data=%h src=%b, want kind=%0d data=%h src=%b",
                 i, ok, o.kind, o.data, o.gsrc, e.kind, e.data, e.gsrc);
      end
    end
  endtask

  task automatic test_active_hold();
    ev_t o, e;
    bit  ok;
    int  d;
    int  t0;
    repeat (4) @(negedge clk_50mhz);
    force_active_if = 1'b1;
    exp_q.push_back(mk(K_IF, 8'hC3, 1'b0));
    exp_q.push_back(mk(K_IF, 8'h3C, 1'b0));
    exp_q.push_back(mk(K_ACK_MENU, 8'h00, 1'b0));
    menu_txq.push_back(pk(8'hC3, 8'h3C, 2'b01));
    repeat (100) @(posedge clk_50mhz);
    #1;
    n_tests++;
    if (obs_q.size() != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL active_hold_wait: events=%0d busy=%b, want 0 events busy=1", obs_q.size(), busy);
    end
    force_active_if = 1'b0;
    d = cyc;
    t0 = -1;
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front(); get_obs(o, ok); n_tests++;
      if (i == 0) t0 = o.cyc;
      if (!ok || o.kind !== e.kind || o.data !== e.data || o.gsrc !== e.gsrc) begin
        n_fail++;
        $display("FAIL active_hold ev%0d: got ok=%0d kind=%0d data=%h src=%b, want kind=%0d data=%h src=%b",
                 i, ok, o.kind, o.data, o.gsrc, e.kind, e.data, e.gsrc);
      end
    end
    n_tests++;
    if (t0 != d + 1) begin
      n_fail++;
      $display("FAIL active_release_latency: strobe in cycle %0d, want %0d", t0, d + 1);
    end
  endtask

  task automatic test_timeout();
    ev_t o, e;
    bit  ok;
    int  t[2];
    repeat (4) @(negedge clk_50mhz);
    exp_q.push_back(mk(K_EXT1, MUTE, 1'b0));
    exp_q.push_back(mk(K_ACK_MENU, 8'h01, 1'b0));
    menu_txq.push_back(pk(MUTE, 8'h44, 2'b10));
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front(); get_obs(o, ok); n_tests++; t[i] = o.cyc;
      if (!ok || o.kind !== e.kind || o.data !== e.data || o.gsrc !== e.gsrc) begin
        n_fail++;
        $display("FAIL timeout ev%0d: got ok=%0d kind=%0d data=%h src=%b, want kind=%0d data=%h src=%b",
                 i, ok, o.kind, o.data, o.gsrc, e.kind, e.data, e.gsrc);
      end
    end
    n_tests++;
    if (t[1] - t[0] < 51 || t[1] - t[0] > 52) begin
      n_fail++;
      $display("FAIL timeout_delay: ack %0d cycles after strobe, want 51..52", t[1] - t[0]);
    end
    while (cyc < t[1] + 1) @(negedge clk_50mhz);
    n_tests++;
    if (busy !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: busy=%b err=%b, want 0 0", busy, err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    ev_t o, e;
    bit  ok;
    repeat (4) @(negedge clk_50mhz);
    exp_q.push_back(mk(K_IF, 8'h61, 1'b0));
    exp_q.push_back(mk(K_IF, MUTE, 1'b0));
    menu_txq.push_back(pk(8'h61, MUTE, 2'b01));
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front(); get_obs(o, ok); n_tests++;
      if (!ok || o.kind !== e.kind || o.data !== e.data || o.gsrc !== e.gsrc) begin
        n_fail++;
        $display("FAIL reset_mid_pre ev%0d: got ok=%0d kind=%0d data=%h src=%b, want kind=%0d data=%h src=%b",
                 i, ok, o.kind, o.data, o.gsrc, e.kind, e.data, e.gsrc);
      end
    end
    // Now waiting for byte2 done that never comes; reset between clock edges.
    @(negedge clk_50mhz); #2;
    n_tests++;
    if (busy !== 1'b1 || tx_byte_if !== MUTE) begin
      n_fail++;
      $display("FAIL reset_mid_busy: busy=%b byte_if=%h, want 1 %h", busy, tx_byte_if, MUTE);
    end
    reset_n_internal = 1'b0;
    #1;
    n_tests++;
    if ({tx_dv_if, tx_dv_ext1, tx_byte_if, tx_byte_ext1, ack_menu, ack_ext,
         err_timeout, busy, grant_src} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h, want 000000", {tx_dv_if, tx_dv_ext1,
               tx_byte_if, tx_byte_ext1, ack_menu, ack_ext, err_timeout, busy, grant_src});
    end
    repeat (3) @(negedge clk_50mhz);
    reset_n_internal = 1'b1;
    exp_q.push_back(mk(K_IF, 8'h61, 1'b0));
    exp_q.push_back(mk(K_IF, MUTE, 1'b0));
    exp_q.push_back(mk(K_ACK_MENU, 8'h01, 1'b0));
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front(); get_obs(o, ok); n_tests++;
      if (!ok || o.kind !== e.kind || o.data !== e.data || o.gsrc !== e.gsrc) begin
        n_fail++;
        $display("FAIL reset_mid_restart ev%0d: got ok=%0d kind=%0d data=%h src=%b, want kind=%0d data=%h src=%b",
                 i, ok, o.kind, o.data, o.gsrc, e.kind, e.data, e.gsrc);
      end
    end
  endtask

  task automatic test_empty_dest();
    ev_t o, e;
    bit  ok;
    repeat (4) @(negedge clk_50mhz);
    exp_q.push_back(mk(K_ACK_EXT, 8'h00, 1'b1));
    ext_txq.push_back(pk(8'h11, 8'h22, 2'b00));
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front(); get_obs(o, ok); n_tests++;
      if (!ok || o.kind !== e.kind || o.data !== e.data || o.gsrc !== e.gsrc) begin
        n_fail++;
        $display("FAIL empty_dest ev%0d: got ok=%0d kind=%0d data=%h src=%b, want kind=%0d data=%h src=%b",
                 i, ok, o.kind, o.data, o.gsrc, e.kind, e.data, e.gsrc);
      end
    end
  endtask

  task automatic test_no_stray();
    repeat (10) @(negedge clk_50mhz);
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL stray_events: %0d unexpected events (first kind=%0d data=%h), want 0",
               obs_q.size(), obs_q[0].kind, obs_q[0].data);
    end
  endtask

  initial begin
    force_active_if = 1'b0;
    inj_done_ext1   = 1'b0;
    test_reset();
    test_tie();
    test_menu_only();
    test_ext_if_only();
    test_active_hold();
    test_timeout();
    test_reset_mid();
    test_empty_dest();
    test_no_stray();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached before summary, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
